// File: rtl/branch_pkg.sv
// Purpose: shared opcode constants, condition enum and opcode decoder for branch resolution.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package branch_pkg;

  localparam int OPC_W = 6;

  // Unsigned-compare branch opcodes
  localparam logic [OPC_W-1:0] OPC_BEQU = 6'h08;
  localparam logic [OPC_W-1:0] OPC_BNEU = 6'h09;
  localparam logic [OPC_W-1:0] OPC_BGEU = 6'h0A;
  localparam logic [OPC_W-1:0] OPC_BGTU = 6'h0B;
  localparam logic [OPC_W-1:0] OPC_BLEU = 6'h0C;
  localparam logic [OPC_W-1:0] OPC_BLTU = 6'h0D;

  // Signed (two's complement) compare branch opcodes
  localparam logic [OPC_W-1:0] OPC_BEQS = 6'h18;
  localparam logic [OPC_W-1:0] OPC_BNES = 6'h19;
  localparam logic [OPC_W-1:0] OPC_BGES = 6'h1A;
  localparam logic [OPC_W-1:0] OPC_BGTS = 6'h1B;
  localparam logic [OPC_W-1:0] OPC_BLES = 6'h1C;
  localparam logic [OPC_W-1:0] OPC_BLTS = 6'h1D;

  typedef enum logic [2:0] {EQ, NE, GE, GT, LE, LT} cond_t;

  typedef struct packed {
    logic  is_branch;
    logic  sgn;
    cond_t cond;
  } dec_t;

  // Non-branch opcodes decode to is_branch=0 so downstream logic can ignore cond.
  function automatic dec_t branch_decode(input logic [OPC_W-1:0] opc);
    dec_t d;
    case (opc)
      OPC_BEQU: d = '{is_branch: 1'b1, sgn: 1'b0, cond: EQ};
      OPC_BNEU: d = '{is_branch: 1'b1, sgn: 1'b0, cond: NE};
      OPC_BGEU: d = '{is_branch: 1'b1, sgn: 1'b0, cond: GE};
      OPC_BGTU: d = '{is_branch: 1'b1, sgn: 1'b0, cond: GT};
      OPC_BLEU: d = '{is_branch: 1'b1, sgn: 1'b0, cond: LE};
      OPC_BLTU: d = '{is_branch: 1'b1, sgn: 1'b0, cond: LT};
      OPC_BEQS: d = '{is_branch: 1'b1, sgn: 1'b1, cond: EQ};
      OPC_BNES: d = '{is_branch: 1'b1, sgn: 1'b1, cond: NE};
      OPC_BGES: d = '{is_branch: 1'b1, sgn: 1'b1, cond: GE};
      OPC_BGTS: d = '{is_branch: 1'b1, sgn: 1'b1, cond: GT};
      OPC_BLES: d = '{is_branch: 1'b1, sgn: 1'b1, cond: LE};
      OPC_BLTS: d = '{is_branch: 1'b1, sgn: 1'b1, cond: LT};
      default:  d = '{is_branch: 1'b0, sgn: 1'b0, cond: EQ};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purpose: evaluate one compare condition on two operands, signed or unsigned.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  cond_t            cond,
  output logic             taken
);

  logic eq;
  logic lt;

  // Every condition is derived from a single equality and a single less-than compare.
  always_comb begin
    eq    = (a == b);
    lt    = sgn ? ($signed(a) < $signed(b)) : (a < b);
    taken = 1'b0;
    case (cond)
      EQ:      taken = eq;
      NE:      taken = !eq;
      GE:      taken = !lt;
      GT:      taken = !lt && !eq;
      LE:      taken = lt || eq;
      LT:      taken = lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose: resolve branch condition/target and hold the result in a one-entry output register.
// Latency: 1 cycle from accepted input to out_valid; 1 result/cycle when out_ready=1.
// Backpressure: in_ready = !out_valid || out_ready (no skid); held result stays stable until taken.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [PC_W-1:0]  pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_branch,
  output logic             out_taken,
  output logic [PC_W-1:0]  out_target,
  output logic [WIDTH-1:0] out_diff,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  dec_t            dec;
  logic            cond_true;
  logic            taken;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] target;
  logic            accept;
  logic            deliver;
  logic            unused_ir;

  // rs/rt fields are consumed upstream by the register file, not here.
  assign unused_ir = ^ir[25:16];

  assign dec = branch_decode(ir[31:26]);

  branch_cond_eval #(.WIDTH(WIDTH)) u_cond (
    .a     (op_a),
    .b     (op_b),
    .sgn   (dec.sgn),
    .cond  (dec.cond),
    .taken (cond_true)
  );

  assign taken   = dec.is_branch && cond_true;
  // Word offset, sign-extended to PC_W before the shift so backward branches wrap correctly.
  assign br_off  = PC_W'($signed(ir[15:0])) << 2;
  assign pc_next = pc + PC_W'(4);
  assign target  = taken ? (pc_next + br_off) : pc_next;

  // rst forces ready so the front end is never stalled by a result that reset is discarding.
  assign in_ready = rst || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign deliver  = out_valid && out_ready;

  // Output register, handshake and flush; a same-cycle deliver+accept swaps in the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_is_branch <= 1'b0;
      out_taken     <= 1'b0;
      out_target    <= '0;
      out_diff      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_is_branch <= dec.is_branch;
      out_taken     <= taken;
      out_target    <= target;
      out_diff      <= op_a - op_b;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating statistics, counted on delivery (including a delivery coincident with flush).
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt  <= '0;
      branch_cnt <= '0;
    end else if (deliver) begin
      if (out_is_branch && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (out_taken && (taken_cnt != '1))      taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit plus hand-written handshake sequences.
module tb_branch_resolve_unit;

  localparam int WIDTH = 32;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int NV    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ir;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [PC_W-1:0]  pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_is_branch;
  logic             out_taken;
  logic [PC_W-1:0]  out_target;
  logic [WIDTH-1:0] out_diff;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] branch_cnt;

  int checks   = 0;
  int failures = 0;
  int m_branch = 0;
  int m_taken  = 0;

  typedef struct {
    logic [5:0]  opc;
    logic [15:0] off;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] diff;
  } vec_t;

  vec_t tv[NV];

  branch_resolve_unit #(.WIDTH(WIDTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ir            (ir),
    .op_a          (op_a),
    .op_b          (op_b),
    .pc            (pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_is_branch (out_is_branch),
    .out_taken     (out_taken),
    .out_target    (out_target),
    .out_diff      (out_diff),
    .taken_cnt     (taken_cnt),
    .branch_cnt    (branch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic drive(input int i);
    in_valid = 1'b1;
    ir       = {tv[i].opc, 10'h0, tv[i].off};
    op_a     = tv[i].a;
    op_b     = tv[i].b;
    pc       = tv[i].pc;
  endtask

  task automatic chk_fields(input string name, input int i);
    chk({name, ".valid"},  out_valid, 1'b1);
    chk({name, ".branch"}, out_is_branch, tv[i].br);
    chk({name, ".taken"},  out_taken, tv[i].tk);
    chk({name, ".target"}, out_target, tv[i].tgt);
    chk({name, ".diff"},   out_diff, tv[i].diff);
  endtask

  task automatic chk_cnts(input string name);
    chk({name, ".branch_cnt"}, branch_cnt, sat(m_branch));
    chk({name, ".taken_cnt"},  taken_cnt, sat(m_taken));
  endtask

  // Count a result the model knows will be delivered at the coming edge.
  task automatic model_deliver(input int i);
    m_branch = m_branch + int'(tv[i].br);
    m_taken  = m_taken + int'(tv[i].tk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            opc    off       a             b             pc            br    tk    tgt           diff
    tv[0]  = '{6'h08, 16'h0004, 32'h5,        32'h5,        32'h100,      1'b1, 1'b1, 32'h114,      32'h0};
    tv[1]  = '{6'h0D, 16'h0004, 32'hFFFFFFFF, 32'h1,        32'h100,      1'b1, 1'b0, 32'h104,      32'hFFFFFFFE};
    tv[2]  = '{6'h1D, 16'hFFFF, 32'hFFFFFFFF, 32'h1,        32'h100,      1'b1, 1'b1, 32'h100,      32'hFFFFFFFE};
    tv[3]  = '{6'h00, 16'h0004, 32'h3,        32'h7,        32'h100,      1'b0, 1'b0, 32'h104,      32'hFFFFFFFC};
    tv[4]  = '{6'h09, 16'h0010, 32'h1,        32'h2,        32'h200,      1'b1, 1'b1, 32'h244,      32'hFFFFFFFF};
    tv[5]  = '{6'h0A, 16'h0001, 32'h2,        32'h2,        32'h0,        1'b1, 1'b1, 32'h8,        32'h0};
    tv[6]  = '{6'h1A, 16'h0001, 32'h80000000, 32'h0,        32'h0,        1'b1, 1'b0, 32'h4,        32'h80000000};
    tv[7]  = '{6'h0B, 16'h0002, 32'h80000000, 32'h0,        32'h1000,     1'b1, 1'b1, 32'h100C,     32'h80000000};
    tv[8]  = '{6'h1B, 16'h8000, 32'h0,        32'hFFFFFFFF, 32'h30000,    1'b1, 1'b1, 32'h10004,    32'h1};
    tv[9]  = '{6'h0C, 16'h0003, 32'h7,        32'h6,        32'h40,       1'b1, 1'b0, 32'h44,       32'h1};
    tv[10] = '{6'h1C, 16'h0003, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h40,       1'b1, 1'b1, 32'h50,       32'h0};
    tv[11] = '{6'h18, 16'h0003, 32'h1,        32'h0,        32'hFFFFFFFC, 1'b1, 1'b0, 32'h0,        32'h1};
    tv[12] = '{6'h19, 16'h0003, 32'h5,        32'h5,        32'h10,       1'b1, 1'b0, 32'h14,       32'h0};
    tv[13] = '{6'h3F, 16'h0003, 32'h0,        32'h1,        32'h10,       1'b0, 1'b0, 32'h14,       32'hFFFFFFFF};
    tv[14] = '{6'h0E, 16'h0003, 32'h1,        32'h2,        32'h0,        1'b0, 1'b0, 32'h4,        32'hFFFFFFFF};
    tv[15] = '{6'h08, 16'h0001, 32'h0,        32'h0,        32'hFFFFFFF8, 1'b1, 1'b1, 32'h0,        32'h0};

    rst = 1'b1; in_valid = 1'b0; ir = '0; op_a = '0; op_b = '0; pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst.in_ready",   in_ready, 1'b1);
    chk("rst.out_valid",  out_valid, 1'b0);
    chk("rst.target",     out_target, 32'h0);
    chk("rst.branch_cnt", branch_cnt, 4'h0);
    chk("rst.taken_cnt",  taken_cnt, 4'h0);
    rst = 1'b0;
    tick();

    // Table: back-to-back with out_ready=1, each result checked one cycle after capture.
    for (int i = 0; i < NV; i++) begin
      drive(i);
      chk($sformatf("tv%0d.in_ready", i), in_ready, 1'b1);
      tick();
      chk_fields($sformatf("tv%0d", i), i);
      model_deliver(i);
    end
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", out_valid, 1'b0);
    chk_cnts("drain");

    // Backpressure: hold tv[0] for 3 cycles while tv[1] is offered.
    drive(0);
    tick();
    out_ready = 1'b0;
    drive(1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_fields($sformatf("bp%0d", c), 0);
      chk($sformatf("bp%0d.in_ready", c), in_ready, 1'b0);
      chk_cnts($sformatf("bp%0d", c));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", in_ready, 1'b1);
    model_deliver(0);
    tick();
    chk_fields("bp.next", 1);
    chk_cnts("bp.next");

    // Flush coincident with delivery: tv[1] counted, offered tv[4] dropped.
    drive(4);
    flush = 1'b1;
    model_deliver(1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1.out_valid", out_valid, 1'b0);
    chk_cnts("fl1");
    tick();
    chk("fl1.dropped", out_valid, 1'b0);

    // Flush with out_ready=0: held tv[0] discarded and not counted.
    drive(0);
    tick();
    in_valid = 1'b1;
    out_ready = 1'b0;
    drive(4);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2.out_valid", out_valid, 1'b0);
    chk_cnts("fl2");
    out_ready = 1'b1;

    // Saturation: 20 taken branches delivered back-to-back.
    for (int k = 0; k < 20; k++) begin
      drive(0);
      tick();
      model_deliver(0);
    end
    in_valid = 1'b0;
    tick();
    chk("sat.branch_cnt", branch_cnt, 4'hF);
    chk("sat.taken_cnt",  taken_cnt, 4'hF);
    chk_cnts("sat");

    // Reset mid-stream with a held result pending.
    drive(4);
    out_ready = 1'b0;
    tick();
    chk("prerst.valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", in_ready, 1'b1);
    tick();
    chk("midrst.out_valid",  out_valid, 1'b0);
    chk("midrst.is_branch",  out_is_branch, 1'b0);
    chk("midrst.taken",      out_taken, 1'b0);
    chk("midrst.target",     out_target, 32'h0);
    chk("midrst.diff",       out_diff, 32'h0);
    chk("midrst.taken_cnt",  taken_cnt, 4'h0);
    chk("midrst.branch_cnt", branch_cnt, 4'h0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
